// File: rtl/multi_vl_pkg.sv
// Shared types and widths for the sequential Booth multiplier (multi_vl).
package multi_vl_pkg;

    localparam int OP_W     = 32;
    localparam int PROD_W   = 64;
    localparam int MAX_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working set carried from one Booth iteration to the next.
    typedef struct packed {
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] a;
        logic [OP_W-1:0]   q;
        logic              qprev;
    } booth_t;

endpackage

// File: rtl/multi_vl_if.sv
// Start/valid handshake and operand/product bus of the multiplier.
interface multi_vl_if;

    logic                             start;
    logic [multi_vl_pkg::OP_W-1:0]    mlier;
    logic [multi_vl_pkg::OP_W-1:0]    mcand;
    logic [multi_vl_pkg::PROD_W-1:0]  prodt;
    logic                             valid;

    modport master (output start, output mlier, output mcand, input prodt, input valid);
    modport slave  (input start, input mlier, input mcand, output prodt, output valid);

endinterface

// File: rtl/multi_vl_booth_step.sv
// One radix-2 Booth iteration; also flags when the remaining multiplier digits are all zero.
module multi_vl_booth_step
    import multi_vl_pkg::*;
(
    input  booth_t cur,
    output booth_t nxt,
    output logic   rest_zero
);

    always_comb begin
        nxt = cur;
        case ({cur.q[0], cur.qprev})
            2'b10:   nxt.p = cur.p - cur.a;
            2'b01:   nxt.p = cur.p + cur.a;
            default: nxt.p = cur.p;
        endcase
        nxt.a     = cur.a << 1;
        nxt.qprev = cur.q[0];
        nxt.q     = {cur.q[OP_W-1], cur.q[OP_W-1:1]};
        // Q equal to pure sign copies of qprev means every remaining digit recodes to 0.
        rest_zero = (nxt.q == {OP_W{nxt.qprev}});
    end

endmodule

// File: rtl/variable_latency_multiplier.sv
// 32x32 signed sequential multiplier with early termination; FSM, working registers and counter.
module variable_latency_multiplier
    import multi_vl_pkg::*;
(
    input logic       clock,
    input logic       reset,
    multi_vl_if.slave bus
);

    state_t            state;
    booth_t            cur;
    booth_t            nxt;
    logic              rest_zero;
    logic [5:0]        k;
    logic [PROD_W-1:0] prodt_q;
    logic              valid_q;
    logic              last;

    multi_vl_booth_step u_step (
        .cur       (cur),
        .nxt       (nxt),
        .rest_zero (rest_zero)
    );

    assign last = rest_zero || (k == 6'(MAX_ITER - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cur     <= '0;
            k       <= '0;
            prodt_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cur.p     <= '0;
                        cur.a     <= {{(PROD_W-OP_W){bus.mcand[OP_W-1]}}, bus.mcand};
                        cur.q     <= bus.mlier;
                        cur.qprev <= 1'b0;
                        k         <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Dropping start mid-operation abandons it; prodt keeps the old result.
                    if (!bus.start) begin
                        state <= IDLE;
                    end else begin
                        cur <= nxt;
                        k   <= k + 6'd1;
                        if (last) begin
                            prodt_q <= nxt.p;
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.prodt = prodt_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_variable_latency_multiplier.sv
// Randomized and directed checks of variable_latency_multiplier against a plain-arithmetic model.
module tb_variable_latency_multiplier;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    multi_vl_if bus ();

    variable_latency_multiplier dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Iteration count straight from its definition: first k whose leftover multiplier is pure sign.
    function automatic int exp_iters(input logic [31:0] m);
        logic signed [31:0] s;
        logic [31:0]        rest;
        s = m;
        for (int i = 1; i <= 32; i++) begin
            rest = 32'(s >>> i);
            if (rest == {32{m[i-1]}}) return i;
        end
        return 32;
    endfunction

    function automatic logic [63:0] exp_prod(input logic [31:0] ml, input logic [31:0] mc);
        longint a, b;
        a = longint'($signed(ml));
        b = longint'($signed(mc));
        return 64'(a * b);
    endfunction

    task automatic run_op(input logic [31:0] ml, input logic [31:0] mc);
        int          edges;
        logic [63:0] p;
        p = exp_prod(ml, mc);
        @(negedge clock);
        chk("idle_valid", 64'(bus.valid), 64'd0);
        bus.mlier = ml;
        bus.mcand = mc;
        bus.start = 1'b1;
        edges = 0;
        while (!bus.valid && edges < 40) begin
            @(negedge clock);
            edges++;
        end
        chk("latency", 64'(edges), 64'(exp_iters(ml) + 1));
        chk("prodt", bus.prodt, p);
        // Result must hold while start stays high, whatever the operands do.
        bus.mlier = $urandom;
        bus.mcand = $urandom;
        repeat (2) @(negedge clock);
        chk("hold_valid", 64'(bus.valid), 64'd1);
        chk("hold_prodt", bus.prodt, p);
        bus.start = 1'b0;
        @(negedge clock);
        chk("drop_valid", 64'(bus.valid), 64'd0);
        chk("idle_prodt", bus.prodt, p);
    endtask

    initial begin
        logic [31:0] ml, mc;
        logic [63:0] last_p;
        bit          rose;

        bus.start = 1'b0;
        bus.mlier = '0;
        bus.mcand = '0;
        #12;
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_prodt", bus.prodt, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op(32'd1238, 32'd12345);
        run_op(32'd12, 32'd23123);
        run_op(32'd3234, 32'd22122);
        run_op(32'd8, 32'd12399);
        run_op(32'hFFFF_FFFF, -32'sd34222);
        run_op(-32'sd10, -32'sd12345);
        run_op(32'h8000_0000, 32'h8000_0000);
        run_op(32'd0, 32'hDEAD_BEEF);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            ml = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ml = -ml;
            mc = $urandom;
            run_op(ml, mc);
        end

        // Abort mid-BUSY: valid never rises, prodt keeps previous result.
        last_p = exp_prod(ml, mc);
        @(negedge clock);
        bus.mlier = 32'h4000_0000;
        bus.mcand = 32'd77;
        bus.start = 1'b1;
        repeat (6) @(negedge clock);
        bus.start = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.valid) rose = 1'b1;
        end
        chk("abort_valid", 64'(rose), 64'd0);
        chk("abort_prodt", bus.prodt, last_p);
        run_op(32'd1238, 32'd12345);

        // Asynchronous reset mid-BUSY clears outputs at once.
        @(negedge clock);
        bus.mlier = 32'h4000_0000;
        bus.mcand = 32'd5;
        bus.start = 1'b1;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy_valid", 64'(bus.valid), 64'd0);
        chk("rst_busy_prodt", bus.prodt, 64'd0);
        @(negedge clock);
        bus.start = 1'b0;
        reset = 1'b1;
        run_op(-32'sd10, -32'sd12345);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/variable_latency_multiplier.md
# variable_latency_multiplier

Sequential 32x32 signed multiplier (`multi_vl`) with data-dependent latency. It uses radix-2 Booth recoding and terminates early once the remaining multiplier digits are all zero. It sits beside the datapath as a multi-cycle arithmetic unit with a level-sensitive start/valid handshake. The worst case is 33 clock edges from accepted start to valid.

## Interface
- No parameters; widths fixed: operand 32, product 64.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (one clock domain; asserted low clears all state)
- `mlier`  in  32  multiplier, two's complement; sampled only when a start is accepted
- `mcand`  in  32  multiplicand, two's complement; sampled only when a start is accepted
- `prodt`  out  64  signed product `mlier*mcand`
- `start`  in  1  level request; held high for the whole operation
- `valid`  out  1  high while `prodt` holds the result of the current request

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with `valid=0`, `prodt=0` and all internal registers at 0.
- IDLE, `start=1` at an edge:
  - A = sign-extended `mcand` (64 bits), Q = `mlier`, qprev = 0, P = 0, k = 0.
  - Go to BUSY.
- BUSY, each edge performs one Booth iteration:
  - {Q[0],qprev}=10: P = P - A.
  - {Q[0],qprev}=01: P = P + A.
  - 00 or 11: no change.
  - Then A <<= 1, qprev = Q[0], Q >>>= 1 (arithmetic shift), k++.
- Termination is checked on the post-iteration values: (Q == {32{qprev}}) or k == 32.
  - On termination, `prodt` = new P and the state goes to DONE.
  - All arithmetic is modulo 2^64, which gives the exact signed product.
- Iteration count N = smallest k ≥ 1 with `mlier>>>k` == {32{`mlier[k-1]`}}, capped at 32. Examples:
  - Non-negative, nonzero operand: N = msb_index + 2.
  - `mlier=0`: N = 1.
  - `mlier=-1`: N = 1.
- DONE: `valid=1` and `prodt` held stable while `start=1`. When `start=0` at an edge, go to IDLE and drop `valid`.
- `start` dropped during BUSY aborts: go to IDLE, `valid` stays 0, `prodt` keeps its previous value.
- `prodt` changes only on completion or reset. It keeps its value in IDLE.
- Operand changes after acceptance are ignored.
- A new request needs at least one edge with `start=0` after DONE.

## Timing
- Acceptance edge E0 (IDLE, `start=1`). The BUSY iterations occur on edges E1..EN.
- `valid` and `prodt` update on edge EN, so latency is N+1 edges from start assertion. Range is 2..33 edges.
- Both outputs are registered; no combinational path from inputs to outputs.
- `valid` falls on the first edge at which `start=0` is sampled in DONE.
- Asserting `reset` low at any time clears outputs immediately, regardless of state.

## Structure
- Shared package `multi_vl_pkg`: state enum (IDLE/BUSY/DONE), constants OP_W=32, PROD_W=64, MAX_ITER=32.
- One sub-module, `multi_vl_booth_step`, which is combinational. It takes P, A, Q, qprev and returns next P, A, Q, qprev plus the termination flag.
- The top level holds the FSM, operand/accumulator registers and the iteration counter.

## Test plan
- Hold `start` for 33 cycles and idle 1 cycle between requests; each case below gives operands -> product, valid edge:
  - 1238 x 12345 -> 15283110, valid at edge 13 (N=12).
  - 12 x 23123 -> 277476, valid at edge 6.
  - 3234 x 22122 -> 71542548, valid at edge 14.
  - 8 x 12399 -> 99192, valid at edge 6.
- Signed operands:
  - -1 x -34222 -> 34222, valid at edge 2.
  - -10 x -12345 -> 123450, valid at edge 6.
  - 0x80000000 x 0x80000000 -> 2^62, valid at edge 33.
- Zero operand: `mlier=0`, any `mcand` -> `prodt=0`, valid at edge 2.
- Handshake:
  - `valid` stays high while `start` is held.
  - `valid` drops one edge after `start=0`.
  - Changing operands in DONE does not alter `prodt`.
- Abort and reset:
  - Drop `start` mid-BUSY (mlier=0x40000000) -> `valid` never rises and `prodt` is unchanged.
  - Pull `reset` low mid-BUSY -> `valid=0` and `prodt=0` immediately.
  - The next request after either completes correctly.
